// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between the ALU and register writeback.
// Takes one request, drives the single-port data RAM for one cycle, waits out
// the RAM read latency and returns an aligned, extended load result (or a
// store completion) over a valid/ready handshake.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned H/W accesses skip the RAM and respond with oRSP_ERR=1
//   undefined -> low address bits are ignored by the lane rules, oRSP_ERR=0
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for a request (once out of reset)
// S_ACCESS | one-cycle RAM access using the registered request
// S_WAIT   | load only: counting down the RAM read latency
// S_RESP   | response held on oRSP_* until writeback accepts it

module mem_access_unit #(
  parameter int RAM_LAT = 1,
  parameter int ADDR_W  = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iREQ_VALID,
  output logic              oREQ_READY,
  input  logic              iREQ_WR,
  input  logic [2:0]        iREQ_FUNCT3,
  input  logic [ADDR_W-1:0] iREQ_ADDR,
  input  logic [31:0]       iREQ_WDATA,
  input  logic [4:0]        iREQ_RD,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [3:0]        oRAM_BE,
  output logic [31:0]       oRAM_DATA,
  input  logic [31:0]       iRAM_DATA,
  output logic              oRSP_VALID,
  input  logic              iRSP_READY,
  output logic              oRSP_WE,
  output logic [4:0]        oRSP_RD,
  output logic [31:0]       oRSP_DATA,
  output logic              oRSP_ERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state;
  logic              run_q;
  logic              req_wr;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic [3:0]        cnt;
  logic              rsp_we;
  logic [4:0]        rsp_rd;
  logic [31:0]       rsp_data;

  logic              is_word;
  logic              is_half;
  logic              misalign;
  logic              access_en;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic [4:0]        shift;
  logic [31:0]       shifted;
  logic [31:0]       load_data;

  // funct3[1] set means word for both loads (010/011/110/111) and stores (x1x)
  assign is_word = req_f3[1];
  assign is_half = ~req_f3[1] & req_f3[0];

`ifdef MISALIGN_TRAP_EN
  logic rsp_err;
  assign misalign = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
  assign oRSP_ERR = rsp_err;
`else
  assign misalign = 1'b0;
  assign oRSP_ERR = 1'b0;
`endif

  // Strobes and RAM buses are only live during a real (non-trapped) access
  assign access_en  = (state == S_ACCESS) & ~misalign;
  assign oRAM_CE    = access_en;
  assign oRAM_RD    = access_en & ~req_wr;
  assign oRAM_WR    = access_en & req_wr;
  assign oRAM_ADDR  = access_en ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
  assign oRAM_BE    = access_en ? lane_be : 4'b0000;
  assign oRAM_DATA  = access_en ? lane_data : 32'd0;

  // ready is held low until the first edge after reset release
  assign oREQ_READY = run_q & (state == S_IDLE);
  assign oRSP_VALID = (state == S_RESP);
  assign oRSP_WE    = rsp_we;
  assign oRSP_RD    = rsp_rd;
  assign oRSP_DATA  = rsp_data;

  // Store byte enables and lane-replicated write data
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = 32'd0;
    if (is_word) begin
      lane_be   = 4'b1111;
      lane_data = req_wdata;
    end else if (is_half) begin
      lane_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{req_wdata[15:0]}};
    end else begin
      lane_be   = 4'b0001 << req_addr[1:0];
      lane_data = {4{req_wdata[7:0]}};
    end
  end

  // Load alignment and sign/zero extension; funct3[2] selects unsigned
  always_comb begin
    shift = 5'd0;
    if (is_half) begin
      shift = {req_addr[1], 4'b0000};
    end else if (!is_word) begin
      shift = {req_addr[1:0], 3'b000};
    end
    shifted   = iRAM_DATA >> shift;
    load_data = shifted;
    if (is_half) begin
      load_data = req_f3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end else if (!is_word) begin
      load_data = req_f3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end
  end

  // Sequencer: request capture, access, latency countdown, response hold
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= S_IDLE;
      run_q     <= 1'b0;
      req_wr    <= 1'b0;
      req_f3    <= 3'd0;
      req_addr  <= '0;
      req_wdata <= 32'd0;
      req_rd    <= 5'd0;
      cnt       <= 4'd0;
      rsp_we    <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (iREQ_VALID && run_q) begin
            req_wr    <= iREQ_WR;
            req_f3    <= iREQ_FUNCT3;
            req_addr  <= iREQ_ADDR;
            req_wdata <= iREQ_WDATA;
            req_rd    <= iREQ_RD;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
`ifdef MISALIGN_TRAP_EN
          rsp_err <= misalign;
`endif
          if (misalign || req_wr) begin
            rsp_we <= 1'b0;
            rsp_rd <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            rsp_data <= misalign ? 32'(req_addr) : 32'd0;
`else
            rsp_data <= 32'd0;
`endif
            state  <= S_RESP;
          end else begin
            cnt   <= 4'(RAM_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            rsp_we   <= 1'b1;
            rsp_rd   <= req_rd;
            rsp_data <= load_data;
            state    <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (iRSP_READY) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test of mem_access_unit with a latency-3 RAM model.
// The RAM model presents read data only in the single cycle the unit should
// sample it, so latency errors surface as wrong data as well as wrong timing.
// Expectations for the misaligned halfword load follow MISALIGN_TRAP_EN.

module tb_mem_access_unit;

  localparam int LAT = 3;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic        iREQ_WR;
  logic [2:0]  iREQ_FUNCT3;
  logic [7:0]  iREQ_ADDR;
  logic [31:0] iREQ_WDATA;
  logic [4:0]  iREQ_RD;
  logic        oRAM_CE;
  logic        oRAM_RD;
  logic        oRAM_WR;
  logic [7:0]  oRAM_ADDR;
  logic [3:0]  oRAM_BE;
  logic [31:0] oRAM_DATA;
  logic [31:0] iRAM_DATA;
  logic        oRSP_VALID;
  logic        iRSP_READY;
  logic        oRSP_WE;
  logic [4:0]  oRSP_RD;
  logic [31:0] oRSP_DATA;
  logic        oRSP_ERR;

  always #5 iCLK = ~iCLK;

  mem_access_unit #(.RAM_LAT(LAT), .ADDR_W(8)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
    .iREQ_WR(iREQ_WR), .iREQ_FUNCT3(iREQ_FUNCT3), .iREQ_ADDR(iREQ_ADDR),
    .iREQ_WDATA(iREQ_WDATA), .iREQ_RD(iREQ_RD),
    .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
    .oRAM_ADDR(oRAM_ADDR), .oRAM_BE(oRAM_BE), .oRAM_DATA(oRAM_DATA),
    .iRAM_DATA(iRAM_DATA),
    .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY),
    .oRSP_WE(oRSP_WE), .oRSP_RD(oRSP_RD), .oRSP_DATA(oRSP_DATA), .oRSP_ERR(oRSP_ERR)
  );

  // RAM model: byte-enabled write, read word delivered LAT edges after the access edge
  logic [31:0]    mem [0:63];
  logic [31:0]    dpipe [0:LAT-1];
  logic [LAT-1:0] vpipe;

  always @(posedge iCLK) begin
    if (oRAM_CE && oRAM_WR) begin
      for (int b = 0; b < 4; b++) begin
        if (oRAM_BE[b]) mem[oRAM_ADDR[7:2]][8*b +: 8] <= oRAM_DATA[8*b +: 8];
      end
    end
    dpipe[0] <= mem[oRAM_ADDR[7:2]];
    vpipe[0] <= oRAM_CE & oRAM_RD;
    for (int k = 1; k < LAT; k++) begin
      dpipe[k] <= dpipe[k-1];
      vpipe[k] <= vpipe[k-1];
    end
  end

  assign iRAM_DATA = vpipe[LAT-1] ? dpipe[LAT-1] : 32'hA5A5A5A5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          lat;
  int          ce_cnt;
  logic [31:0] s_data;
  logic        s_we;
  logic        s_err;
  logic [4:0]  s_rd;
  logic [7:0]  s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_ram_wr;
  logic        s_ram_rd;

  // Present a request and return #1 after the edge that accepted it
  task automatic accept(input logic wr, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    iREQ_WR = wr; iREQ_FUNCT3 = f3; iREQ_ADDR = addr; iREQ_WDATA = wdata; iREQ_RD = rd;
    iREQ_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (oREQ_READY) break;
      @(posedge iCLK); #1;
    end
    check_val("req_ready_seen", oREQ_READY, 1'b1);
    @(posedge iCLK); #1;
    iREQ_VALID = 1'b0;
  endtask

  // Watch RAM strobes and count edges until the response shows up
  task automatic collect(input logic hold);
    logic got;
    got = 1'b0; lat = 0; ce_cnt = 0;
    s_addr = 8'h00; s_be = 4'h0; s_wdata = 32'd0; s_ram_wr = 1'b0; s_ram_rd = 1'b0;
    iRSP_READY = ~hold;
    for (int i = 0; i < 40; i++) begin
      if (oRAM_CE) begin
        ce_cnt++;
        s_addr = oRAM_ADDR; s_be = oRAM_BE; s_wdata = oRAM_DATA;
        s_ram_wr = oRAM_WR; s_ram_rd = oRAM_RD;
      end
      if (oRSP_VALID) begin
        got = 1'b1;
        break;
      end
      @(posedge iCLK); #1;
      lat++;
    end
    check_val("rsp_valid_seen", got, 1'b1);
    s_data = oRSP_DATA; s_we = oRSP_WE; s_rd = oRSP_RD; s_err = oRSP_ERR;
    if (!hold) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic store_chk(input string tag, input logic [2:0] f3, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [7:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
    accept(1'b1, f3, addr, wdata, 5'd7);
    collect(1'b0);
    check_val({tag, "_lat"},    lat, 1);
    check_val({tag, "_ce"},     ce_cnt, 1);
    check_val({tag, "_wr"},     s_ram_wr, 1'b1);
    check_val({tag, "_rd"},     s_ram_rd, 1'b0);
    check_val({tag, "_addr"},   s_addr, exp_addr);
    check_val({tag, "_be"},     s_be, exp_be);
    check_val({tag, "_wdata"},  s_wdata, exp_data);
    check_val({tag, "_rsp_we"}, s_we, 1'b0);
    check_val({tag, "_rsp_rd"}, s_rd, 5'd0);
    check_val({tag, "_rsp_d"},  s_data, 32'd0);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [7:0] addr,
                          input logic [4:0] rd, input logic [31:0] exp_data);
    accept(1'b0, f3, addr, 32'hFFFF_FFFF, rd);
    collect(1'b0);
    check_val({tag, "_data"}, s_data, exp_data);
    check_val({tag, "_lat"},  lat, LAT + 1);
    check_val({tag, "_we"},   s_we, 1'b1);
    check_val({tag, "_rd"},   s_rd, rd);
    check_val({tag, "_ce"},   ce_cnt, 1);
    check_val({tag, "_strb"}, s_ram_rd, 1'b1);
    check_val({tag, "_err"},  s_err, 1'b0);
  endtask

  task automatic reset_pulse();
    iRST = 1'b0;
    #1;
    check_val("rst_ready", oREQ_READY, 1'b0);
    check_val("rst_ce",    oRAM_CE, 1'b0);
    check_val("rst_wr",    oRAM_WR, 1'b0);
    check_val("rst_valid", oRSP_VALID, 1'b0);
    check_val("rst_data",  oRSP_DATA, 32'd0);
    check_val("rst_rspwe", oRSP_WE, 1'b0);
    check_val("rst_rsprd", oRSP_RD, 5'd0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check_val("rel_ready", oREQ_READY, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iRST = 1'b0; iREQ_VALID = 1'b0; iREQ_WR = 1'b0; iREQ_FUNCT3 = 3'd0;
    iREQ_ADDR = 8'h00; iREQ_WDATA = 32'd0; iREQ_RD = 5'd0; iRSP_READY = 1'b1;

    // power-on reset
    repeat (3) @(posedge iCLK);
    #1;
    check_val("por_ready", oREQ_READY, 1'b0);
    check_val("por_ce",    oRAM_CE, 1'b0);
    check_val("por_valid", oRSP_VALID, 1'b0);
    check_val("por_err",   oRSP_ERR, 1'b0);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check_val("por_rel_ready", oREQ_READY, 1'b1);

    // word store / load
    store_chk("sw10", F_W, 8'h10, 32'hDEADBEEF, 8'h10, 4'b1111, 32'hDEADBEEF);
    load_chk ("lw10", F_W, 8'h10, 5'd1, 32'hDEADBEEF);

    // byte/half loads with sign and zero extension
    store_chk("sw10b", F_W, 8'h10, 32'h80FF1234, 8'h10, 4'b1111, 32'h80FF1234);
    load_chk ("lb13",  F_B,    8'h13, 5'd5,  32'hFFFFFF80);
    load_chk ("lbu13", F_BU,   8'h13, 5'd6,  32'h00000080);
    load_chk ("lhu12", F_HU,   8'h12, 5'd7,  32'h000080FF);
    load_chk ("lh12",  F_H,    8'h12, 5'd8,  32'hFFFF80FF);
    load_chk ("lb11",  F_B,    8'h11, 5'd9,  32'h00000012);
    load_chk ("lhu10", F_HU,   8'h10, 5'd10, 32'h00001234);
    load_chk ("f3_110", 3'b110, 8'h10, 5'd31, 32'h80FF1234);

    // sub-word stores: lanes, replication, merge into the RAM word
    store_chk("sw20",  F_W,    8'h20, 32'h11223344, 8'h20, 4'b1111, 32'h11223344);
    store_chk("sh22",  F_H,    8'h22, 32'h0000ABCD, 8'h20, 4'b1100, 32'hABCDABCD);
    load_chk ("lw20a", F_W,    8'h20, 5'd2, 32'hABCD3344);
    store_chk("sb21",  F_B,    8'h21, 32'h000000EE, 8'h20, 4'b0010, 32'hEEEEEEEE);
    store_chk("sb23",  F_B,    8'h23, 32'h12345677, 8'h20, 4'b1000, 32'h77777777);
    load_chk ("lw20b", F_W,    8'h20, 5'd3, 32'h77CDEE44);
    store_chk("sw_f3_011", 3'b011, 8'h30, 32'h00000000, 8'h30, 4'b1111, 32'h00000000);

    // misaligned halfword load
    accept(1'b0, F_H, 8'h21, 32'd0, 5'd4);
    collect(1'b0);
`ifdef MISALIGN_TRAP_EN
    check_val("lh21_lat",  lat, 1);
    check_val("lh21_ce",   ce_cnt, 0);
    check_val("lh21_err",  s_err, 1'b1);
    check_val("lh21_we",   s_we, 1'b0);
    check_val("lh21_data", s_data, 32'h00000021);
`else
    check_val("lh21_lat",  lat, LAT + 1);
    check_val("lh21_addr", s_addr, 8'h20);
    check_val("lh21_err",  s_err, 1'b0);
    check_val("lh21_we",   s_we, 1'b1);
    check_val("lh21_data", s_data, 32'hFFFFEE44);
`endif

    // writeback back-pressure with a new request waiting
    accept(1'b0, F_W, 8'h10, 32'd0, 5'd12);
    collect(1'b1);
    check_val("bp_data0", s_data, 32'h80FF1234);
    iREQ_WR = 1'b1; iREQ_FUNCT3 = F_W; iREQ_ADDR = 8'h30; iREQ_WDATA = 32'h55555555;
    iREQ_RD = 5'd0; iREQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK); #1;
      check_val("bp_valid", oRSP_VALID, 1'b1);
      check_val("bp_data",  oRSP_DATA, 32'h80FF1234);
      check_val("bp_we",    oRSP_WE, 1'b1);
      check_val("bp_rd",    oRSP_RD, 5'd12);
      check_val("bp_ready", oREQ_READY, 1'b0);
      check_val("bp_ce",    oRAM_CE, 1'b0);
    end
    iRSP_READY = 1'b1;
    @(posedge iCLK); #1;
    check_val("bp_done_valid", oRSP_VALID, 1'b0);
    check_val("bp_done_ready", oREQ_READY, 1'b1);
    iREQ_VALID = 1'b0;
    @(posedge iCLK); #1;
    check_val("bp_no_accept", oRAM_CE, 1'b0);
    load_chk("lw30_keep", F_W, 8'h30, 5'd13, 32'h00000000);

    // reset during a store ACCESS cycle: the write must not land
    accept(1'b1, F_W, 8'h30, 32'hFFFFFFFF, 5'd0);
    reset_pulse();
    load_chk("lw30_abort", F_W, 8'h30, 5'd14, 32'h00000000);

    // reset during WAIT of a load, then a clean load
    accept(1'b0, F_W, 8'h10, 32'd0, 5'd15);
    @(posedge iCLK); #1;
    reset_pulse();
    load_chk("lw10_post", F_W, 8'h10, 5'd16, 32'h80FF1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
